// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and receiver.
// The UART_FIFO_TX_PARITY_EN build adds an even-parity bit to every frame.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned w, input bit parity);
    return w + 2 + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_count;

  assign o_bit_end = (r_count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart || o_bit_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops batches of up to N words from a FIFO and sends them 8N1.
// Define UART_FIFO_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned N            = 2,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int unsigned WN          = $clog2(N + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [WN-1:0]       i_can_pop,
  input  logic [N-1:0][W-1:0] i_pop_data,
  output logic [WN-1:0]       o_pop,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_word_done
);

  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  state_t              r_state;
  state_t              w_state_d;
  logic [N-1:0][W-1:0] r_buf;
  logic [IW-1:0]       r_idx;
  logic [WN-1:0]       r_cnt;
  logic [BW-1:0]       r_bit;
  logic [WN-1:0]       w_k;
  logic                w_bit_end;
  logic                w_more;
  logic                w_last_bit;

  assign w_k        = (i_can_pop > WN'(N)) ? WN'(N) : i_can_pop;
  assign w_more     = (int'(r_idx) + 1) < int'(r_cnt);
  assign w_last_bit = (r_bit == BW'(W - 1));

  // Held in reload while idle so the start bit always gets a full period.
  uart_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(r_state == IDLE),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    o_tx        = 1'b1;
    o_pop       = '0;
    o_busy      = (r_state != IDLE);
    o_word_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_can_pop != '0) begin
          o_pop     = i_rst ? '0 : w_k;
          w_state_d = START;
        end
      end
      START: begin
        o_tx = 1'b0;
        if (w_bit_end) w_state_d = DATA;
      end
      DATA: begin
        o_tx = r_buf[r_idx][r_bit];
        if (w_bit_end && w_last_bit) begin
`ifdef UART_FIFO_TX_PARITY_EN
          w_state_d = PARITY;
`else
          w_state_d = STOP;
`endif
        end
      end
`ifdef UART_FIFO_TX_PARITY_EN
      PARITY: begin
        o_tx = ^r_buf[r_idx];
        if (w_bit_end) w_state_d = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          o_word_done = 1'b1;
          w_state_d   = w_more ? START : IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_can_pop != '0) begin
            r_idx <= '0;
            r_cnt <= w_k;
            r_bit <= '0;
          end
        end
        DATA: begin
          if (w_bit_end) r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
        end
        STOP: begin
          if (w_bit_end && w_more) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Buffer is a snapshot taken in the pop cycle; later FIFO activity cannot disturb it.
  always_ff @(posedge i_clk) begin
    if (r_state == IDLE && i_can_pop != '0) begin
      for (int i = 0; i < N; i++) begin
        if (WN'(i) < w_k) r_buf[i] <= i_pop_data[i];
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx: a FIFO model feeds the DUT and a UART monitor decodes tx.
module tb_uart_fifo_tx;

  localparam int CPB = 4;
  localparam int W   = 8;
  localparam int N   = 2;
  localparam int WN  = 2;
`ifdef UART_FIFO_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = CPB * FB;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [WN-1:0]       can_pop;
  logic [WN-1:0]       pop;
  logic [N-1:0][W-1:0] pop_data;
  logic                tx;
  logic                busy;
  logic                wd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem[32];
  int         head = 0;
  int         tail = 0;
  int         fifo_cnt;
  logic [7:0] exp_bytes[$];
  int         exp_pop[$];

  always #5 clk = ~clk;

  uart_fifo_tx #(
    .W           (W),
    .N           (N),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_can_pop  (can_pop),
    .i_pop_data (pop_data),
    .o_pop      (pop),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_word_done(wd)
  );

  // FIFO model: can_pop reports up to 3 so the DUT's clamp to N is exercised.
  assign fifo_cnt    = tail - head;
  assign can_pop     = (fifo_cnt > 3) ? 2'd3 : 2'(fifo_cnt);
  assign pop_data[0] = mem[head % 32];
  assign pop_data[1] = mem[(head + 1) % 32];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    head <= head + int'(pop);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_it);
    mem[tail % 32] = b;
    tail++;
    if (expect_it) exp_bytes.push_back(b);
  endtask

  task automatic wait_pop(output int c);
    int n = 0;
    c = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pop == '0 && n < 500);
    if (pop == '0) check("pop_timeout", 32'(pop), 32'd1);
    else c = cyc;
  endtask

  task automatic wait_wd(output int c);
    int n = 0;
    c = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wd && n < 500);
    if (!wd) check("word_done_timeout", 32'(wd), 32'd1);
    else c = cyc;
  endtask

  // Monitor: decodes frames on tx mid-bit and checks pops and word_done placement.
  initial begin
    bit         act = 1'b0;
    int         t   = 0;
    int         b;
    logic [7:0] sh  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (wd) check("wd_in_rst", 32'(wd), 32'd0);
        act = 1'b0;
      end else begin
        if (pop != '0) begin
          check("pop_le_can", 32'(pop <= can_pop), 32'd1);
          check("pop_only_idle", 32'(busy), 32'd0);
          if (exp_pop.size() == 0) check("pop_unexpected", 32'(pop), 32'd0);
          else check("pop_n", 32'(pop), 32'(exp_pop.pop_front()));
        end
        if (act) t++;
        else if (tx == 1'b0) begin
          act = 1'b1;
          t   = 0;
          sh  = '0;
        end
        if (act && t == FRAME - 1) check("word_done", 32'(wd), 32'd1);
        else if (wd) check("wd_spur", 32'(wd), 32'd0);
        if (act && (t % CPB) == CPB / 2) begin
          b = t / CPB;
          if (b == 0) check("start_bit", 32'(tx), 32'd0);
          else if (b <= W) sh[b-1] = tx;
`ifdef UART_FIFO_TX_PARITY_EN
          else if (b == W + 1) begin
            if (exp_bytes.size() != 0) check("parity_bit", 32'(tx), 32'(^exp_bytes[0]));
          end
`endif
          else if (b == FB - 1) begin
            check("stop_bit", 32'(tx), 32'd1);
            if (exp_bytes.size() == 0) check("byte_unexpected", 32'(sh), 32'hFFFF);
            else check("byte", 32'(sh), 32'(exp_bytes.pop_front()));
          end
        end
        if (act && t == FRAME - 1) act = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, p2, p3, w, w2, errs;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_wd", 32'(wd), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single word
    push(8'hA5, 1'b1);
    exp_pop.push_back(1);
    wait_pop(p);
    @(negedge clk);
    check("pop_one_cycle", 32'(pop), 32'd0);
    wait_wd(w);
    check("t1_latency", 32'(w - p), 32'(FRAME));
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Two-word batch, back-to-back frames
    @(posedge clk); #1;
    push(8'h81, 1'b1);
    push(8'h3C, 1'b1);
    exp_pop.push_back(2);
    wait_pop(p);
    wait_wd(w);
    check("t2_first", 32'(w - p), 32'(FRAME));
    wait_wd(w2);
    check("t2_second", 32'(w2 - w), 32'(FRAME));
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'd0);

    // Five words with can_pop clamped: pops 2, 2, 1 with a single idle cycle between batches
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    exp_pop.push_back(2);
    exp_pop.push_back(2);
    exp_pop.push_back(1);
    wait_pop(p);
    wait_pop(p2);
    check("t3_gap1", 32'(p2 - p), 32'(2 * FRAME + 1));
    check("t3_gap_tx_high", 32'(tx), 32'd1);
    wait_pop(p3);
    check("t3_gap2", 32'(p3 - p2), 32'(2 * FRAME + 1));
    wait_wd(w);
    check("t3_last", 32'(w - p3), 32'(FRAME));
    @(negedge clk);

    // Reset during DATA bit 3 drops the word
    @(posedge clk); #1;
    push(8'h5A, 1'b0);
    exp_pop.push_back(1);
    wait_pop(p);
    repeat (18) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pop", 32'(pop), 32'd0);
    check("mid_rst_wd", 32'(wd), 32'd0);
    @(posedge clk); #1;
    push(8'h66, 1'b1);
    exp_pop.push_back(1);
    wait_pop(p);
    wait_wd(w);
    check("post_rst_latency", 32'(w - p), 32'(FRAME));

    // Empty FIFO holds IDLE
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (pop != '0 || tx != 1'b1 || busy != 1'b0 || wd != 1'b0) errs++;
    end
    check("idle_hold", 32'(errs), 32'd0);

`ifdef UART_FIFO_TX_PARITY_EN
    @(posedge clk); #1;
    push(8'h07, 1'b1);
    exp_pop.push_back(1);
    wait_pop(p);
    wait_wd(w);
    check("parity_frame_len", 32'(w - p), 32'd44);
`endif

    repeat (5) @(negedge clk);
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("pops_left", 32'(exp_pop.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
